// File: rtl/tcm_port_arbiter.sv
// Arbitrates the core's I-fetch and D ports onto one single-ported TCM bus.
// One transaction in flight; D has priority, bounded by a starvation counter for I.
module tcm_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_i_rd_i,
   input  logic [31:0] mem_i_pc_i,
   output logic        mem_i_accept_o,
   output logic        mem_i_valid_o,
   output logic        mem_i_error_o,
   output logic [31:0] mem_i_inst_o,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic [10:0] mem_d_req_tag_i,
   input  logic        mem_d_flush_i,
   input  logic        mem_d_invalidate_i,
   input  logic        mem_d_writeback_i,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [31:0] mem_d_data_rd_o,
   output logic [10:0] mem_d_resp_tag_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_wr_o,
   output logic        mem_rd_o,
   output logic [3:0]  mem_wr_o,
   input  logic        mem_accept_i,
   input  logic        mem_ack_i,
   input  logic        mem_error_i,
   input  logic [31:0] mem_data_rd_i
);

   localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
   localparam logic [7:0] TLIM = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  starve_cnt;
   logic [7:0]  timer;
   logic        own_d;
   logic [31:0] req_addr, req_data;
   logic        req_rd;
   logic [3:0]  req_wr;
   logic [10:0] req_tag;
   logic        resp_err, resp_err_nxt, load_resp;
   logic [31:0] resp_data, resp_data_nxt, ack_data;

   logic d_req, d_mnt, i_win, grant_i, grant_d, timed_out, strobe, resp_i, resp_d;

   assign d_req     = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
   assign d_mnt     = !mem_d_rd_i && (mem_d_wr_i == 4'd0);
   assign i_win     = mem_i_rd_i && (!d_req || starve_cnt == SLIM);
   assign grant_i   = (state == IDLE) && i_win;
   assign grant_d   = (state == IDLE) && d_req && !i_win;
   assign timed_out = (state == REQ || state == WAIT) && timer == TLIM;
   assign strobe    = (state == REQ) && !timed_out;
   // Reads only return data on a clean ack; writes and errors report zero.
   assign ack_data  = (mem_error_i || req_wr != 4'd0) ? 32'd0 : mem_data_rd_i;

   always_comb begin
      state_nxt     = state;
      load_resp     = 1'b0;
      resp_err_nxt  = 1'b0;
      resp_data_nxt = 32'd0;
      case (state)
         IDLE: begin
            if (grant_d && d_mnt) begin
               state_nxt = RESP;
               load_resp = 1'b1;
            end else if (grant_d || grant_i) begin
               state_nxt = REQ;
            end
         end
         REQ, WAIT: begin
            if (timed_out) begin
               state_nxt    = RESP;
               load_resp    = 1'b1;
               resp_err_nxt = 1'b1;
            end else if (mem_ack_i && (state == WAIT || mem_accept_i)) begin
               state_nxt     = RESP;
               load_resp     = 1'b1;
               resp_err_nxt  = mem_error_i;
               resp_data_nxt = ack_data;
            end else if (state == REQ && mem_accept_i) begin
               state_nxt = WAIT;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         timer      <= 8'd0;
         own_d      <= 1'b0;
         req_addr   <= 32'd0;
         req_data   <= 32'd0;
         req_rd     <= 1'b0;
         req_wr     <= 4'd0;
         req_tag    <= 11'd0;
         resp_err   <= 1'b0;
         resp_data  <= 32'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            timer <= 8'd0;
         else if (state == REQ || state == WAIT)
            timer <= timer + 8'd1;
         if (grant_i) begin
            starve_cnt <= 4'd0;
            own_d      <= 1'b0;
            req_addr   <= mem_i_pc_i;
            req_data   <= 32'd0;
            req_rd     <= 1'b1;
            req_wr     <= 4'd0;
            req_tag    <= 11'd0;
         end else if (grant_d) begin
            if (mem_i_rd_i && starve_cnt != 4'hF)
               starve_cnt <= starve_cnt + 4'd1;
            own_d    <= 1'b1;
            req_addr <= mem_d_addr_i;
            req_data <= mem_d_data_wr_i;
            req_rd   <= mem_d_rd_i;
            req_wr   <= mem_d_wr_i;
            req_tag  <= mem_d_req_tag_i;
         end
         if (load_resp) begin
            resp_err  <= resp_err_nxt;
            resp_data <= resp_data_nxt;
         end
      end
   end

   assign resp_i = (state == RESP) && !own_d;
   assign resp_d = (state == RESP) && own_d;

   assign mem_i_accept_o   = grant_i;
   assign mem_d_accept_o   = grant_d;
   assign mem_i_valid_o    = resp_i;
   assign mem_i_error_o    = resp_i && resp_err;
   assign mem_i_inst_o     = resp_i ? resp_data : 32'd0;
   assign mem_d_ack_o      = resp_d;
   assign mem_d_error_o    = resp_d && resp_err;
   assign mem_d_data_rd_o  = resp_d ? resp_data : 32'd0;
   assign mem_d_resp_tag_o = resp_d ? req_tag : 11'd0;

   // Downstream strobes are only live in REQ and drop on the timeout cycle.
   assign mem_addr_o    = strobe ? (req_addr & 32'hFFFF_FFFC) : 32'd0;
   assign mem_data_wr_o = strobe ? req_data : 32'd0;
   assign mem_rd_o      = strobe && req_rd;
   assign mem_wr_o      = strobe ? req_wr : 4'd0;

endmodule
